// File: rtl/tx_sched_pkg.sv
// Shared types and defaults for the tx_sched frame scheduler.
package tx_sched_pkg;

  typedef enum logic [1:0] {StIdle, StStart, StBusy, StGap} state_e;

  localparam int unsigned DefDw          = 26;
  localparam int unsigned DefFrameCycles = 32;
  localparam int unsigned DefGapCycles   = 2;
  localparam int unsigned FrameCntW      = 16;

  // Counter width for a down-counter holding values below n; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tx_sched_rr_arbiter.sv
// Combinational round-robin grant: first valid requester at or after rr_ptr wins.
module rr_arbiter #(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0]         req_valid,
  input  logic [$clog2(NREQ)-1:0] rr_ptr,
  output logic [NREQ-1:0]         gnt,
  output logic [$clog2(NREQ)-1:0] idx
);

  localparam int unsigned IW = $clog2(NREQ);

  logic [IW-1:0] cand;
  logic          found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = IW'((32'(rr_ptr) + k) % NREQ);
      if (!found && req_valid[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/tx_sched.sv
// Round-robin frame scheduler feeding one serializer channel.
// Optional frame counter port enabled by defining TX_SCHED_CNT_EN.
module tx_sched
  import tx_sched_pkg::*;
#(
  parameter int unsigned NREQ         = 4,
  parameter int unsigned DW           = DefDw,
  parameter int unsigned FRAME_CYCLES = DefFrameCycles,
  parameter int unsigned GAP_CYCLES   = DefGapCycles
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*DW-1:0]      req_data,
  output logic [NREQ-1:0]         req_ready,
  output logic                    tx_start,
  output logic [DW-1:0]           tx_din,
  output logic                    busy,
  output logic [$clog2(NREQ)-1:0] grant_id
`ifdef TX_SCHED_CNT_EN
  ,
  output logic [FrameCntW-1:0]    frame_cnt
`endif
);

  localparam int unsigned IW = $clog2(NREQ);
  localparam int unsigned FW = cnt_width(FRAME_CYCLES);
  localparam int unsigned GW = cnt_width(GAP_CYCLES + 1);

  state_e        state_q;
  logic [IW-1:0] rr_ptr_q;
  logic [FW-1:0] frm_cnt_q;
  logic [GW-1:0] gap_cnt_q;
  logic [NREQ-1:0] arb_gnt;
  logic [IW-1:0]   arb_idx;
  logic            accept;

  rr_arbiter #(
    .NREQ(NREQ)
  ) u_arb (
    .req_valid(req_valid),
    .rr_ptr   (rr_ptr_q),
    .gnt      (arb_gnt),
    .idx      (arb_idx)
  );

  // Gated by rst so req_ready is zero while reset is held, even with valids present.
  assign req_ready = (state_q == StIdle && !rst) ? arb_gnt : '0;
  assign accept    = |req_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      rr_ptr_q  <= '0;
      frm_cnt_q <= '0;
      gap_cnt_q <= '0;
      tx_start  <= 1'b0;
      tx_din    <= '0;
      busy      <= 1'b0;
      grant_id  <= '0;
`ifdef TX_SCHED_CNT_EN
      frame_cnt <= '0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            tx_din   <= req_data[arb_idx*DW +: DW];
            grant_id <= arb_idx;
            rr_ptr_q <= (arb_idx == IW'(NREQ - 1)) ? '0 : arb_idx + 1'b1;
            tx_start <= 1'b1;
            busy     <= 1'b1;
            state_q  <= StStart;
          end
        end
        StStart: begin
          tx_start  <= 1'b0;
          frm_cnt_q <= FW'(FRAME_CYCLES - 2);
          state_q   <= StBusy;
`ifdef TX_SCHED_CNT_EN
          frame_cnt <= frame_cnt + 1'b1;
`endif
        end
        StBusy: begin
          if (frm_cnt_q == '0) begin
            if (GAP_CYCLES > 0) begin
              gap_cnt_q <= GW'(GAP_CYCLES - 1);
              state_q   <= StGap;
            end else begin
              busy    <= 1'b0;
              state_q <= StIdle;
            end
          end else begin
            frm_cnt_q <= frm_cnt_q - 1'b1;
          end
        end
        StGap: begin
          if (gap_cnt_q == '0) begin
            busy    <= 1'b0;
            state_q <= StIdle;
          end else begin
            gap_cnt_q <= gap_cnt_q - 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_sched.sv
// Scoreboard bench for tx_sched: timing-level reference model plus a second
// short-frame, zero-gap instance.
`timescale 1ns/1ps
module tb_tx_sched;

  localparam int unsigned NREQ = 4;
  localparam int unsigned DW   = 26;
  localparam int unsigned FC   = 32;
  localparam int unsigned GC   = 2;
  localparam logic [DW-1:0] W2 = 26'h1234567;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NREQ-1:0]    req_valid, req_ready;
  logic [NREQ*DW-1:0] req_data;
  logic               tx_start, busy;
  logic [DW-1:0]      tx_din;
  logic [1:0]         grant_id;

  logic [1:0]    rv2, rr2;
  logic [2*DW-1:0] rd2;
  logic          ts2, busy2, gid2;
  logic [DW-1:0] td2;
`ifdef TX_SCHED_CNT_EN
  logic [15:0] frame_cnt, frame_cnt2;
`endif

  tx_sched #(.NREQ(NREQ), .DW(DW), .FRAME_CYCLES(FC), .GAP_CYCLES(GC)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .tx_start(tx_start), .tx_din(tx_din), .busy(busy), .grant_id(grant_id)
`ifdef TX_SCHED_CNT_EN
    , .frame_cnt(frame_cnt)
`endif
  );

  tx_sched #(.NREQ(2), .DW(DW), .FRAME_CYCLES(2), .GAP_CYCLES(0)) dut2 (
    .clk(clk), .rst(rst), .req_valid(rv2), .req_data(rd2), .req_ready(rr2),
    .tx_start(ts2), .tx_din(td2), .busy(busy2), .grant_id(gid2)
`ifdef TX_SCHED_CNT_EN
    , .frame_cnt(frame_cnt2)
`endif
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int            cyc;
    int            id;
    logic [DW-1:0] data;
  } exp_t;
  exp_t sb[$];

  // Requester state and reference model
  logic [NREQ-1:0] have, pause, acc;
  logic [DW-1:0]   word [NREQ];
  bit              cont_mode, rand_mode;
  int              m_ptr, m_next_ok, nstarts;

  function automatic logic [DW-1:0] rnd_word();
    return DW'($urandom());
  endfunction

  // Model: after accept at cycle k, start is seen at k+1 and the next accept
  // is possible at k+1+FC+GC; busy covers the cycles in between.
  task automatic model_check();
    logic [NREQ-1:0] exp_rdy;
    logic            exp_busy;
    exp_rdy  = '0;
    exp_busy = (cyc < m_next_ok);
    if (!exp_busy && req_valid != '0) begin
      for (int k = 0; k < NREQ; k++) begin
        int c;
        c = (m_ptr + k) % NREQ;
        if (req_valid[c]) begin
          exp_rdy[c] = 1'b1;
          sb.push_back('{cyc + 1, c, word[c]});
          m_ptr     = (c + 1) % NREQ;
          m_next_ok = cyc + 1 + FC + GC;
          break;
        end
      end
    end
    chk("req_ready", req_ready, exp_rdy);
    chk("busy", busy, exp_busy);
  endtask

  task automatic step();
    @(negedge clk);
    have = have & ~acc;
    for (int i = 0; i < NREQ; i++) begin
      if (cont_mode && !have[i]) begin
        have[i] = 1'b1;
        word[i] = rnd_word();
      end
      if (rand_mode) begin
        if (!have[i] && $urandom_range(0, 9) == 0) begin
          have[i] = 1'b1;
          word[i] = rnd_word();
        end
        pause[i] = ($urandom_range(0, 3) == 0);
      end else begin
        pause[i] = 1'b0;
      end
      req_data[i*DW +: DW] = word[i];
    end
    req_valid = have & ~pause;
    #1;
    model_check();
    acc = req_valid & req_ready;
  endtask

  // Scoreboard monitor for the main instance
  exp_t e;
  always @(negedge clk) begin
    if (!rst) begin
`ifdef TX_SCHED_CNT_EN
      chk("frame_cnt", frame_cnt, 64'(nstarts % 65536));
`endif
      if (tx_start) begin
        nstarts++;
        if (sb.size() == 0) begin
          chk("unexpected_start", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("start_cycle", cyc, e.cyc);
          chk("grant_id", grant_id, e.id);
          chk("tx_din", tx_din, e.data);
        end
      end
    end
  end

  // Monitor for the FRAME_CYCLES=2, GAP_CYCLES=0 instance
  int last2 = -1;
  int n2 = 0;
  int n2r = 0;
  always @(negedge clk) begin
    if (rst) begin
      last2 = -1;
      n2r   = 0;
    end else begin
`ifdef TX_SCHED_CNT_EN
      chk("dut2_frame_cnt", frame_cnt2, 64'(n2r));
`endif
      if (ts2) begin
        if (last2 >= 0) chk("dut2_spacing", cyc - last2, 3);
        chk("dut2_din", td2, W2);
        chk("dut2_grant", gid2, 0);
        chk("dut2_busy", busy2, 1);
        chk("dut2_ready_in_start", rr2, 0);
        n2++;
        n2r++;
        last2 = cyc;
      end
    end
  end

  initial begin
    bit got;
    req_valid = '1;
    req_data  = '0;
    rv2       = 2'b01;
    rd2       = {{DW{1'b0}}, W2};
    have      = '0;
    pause     = '0;
    acc       = '0;
    cont_mode = 1'b0;
    rand_mode = 1'b0;
    m_ptr     = 0;
    m_next_ok = 0;
    nstarts   = 0;
    for (int i = 0; i < NREQ; i++) word[i] = '0;

    repeat (3) @(negedge clk);
    chk("reset_req_ready", req_ready, 0);
    chk("reset_tx_start", tx_start, 0);
    chk("reset_tx_din", tx_din, 0);
    chk("reset_busy", busy, 0);
    chk("reset_grant_id", grant_id, 0);
    req_valid = '0;
    rst = 1'b0;

    // Single requester 2
    have[2] = 1'b1;
    word[2] = 26'h0F1117E;
    step();
    chk("first_grant_onehot", req_ready, 4'b0100);

    // Requester 1 arrives mid-frame; must wait for IDLE
    repeat (5) step();
    have[1] = 1'b1;
    word[1] = 26'h2ABCDEF;
    repeat (80) step();

    // All requesters continuously valid
    cont_mode = 1'b1;
    repeat (6 * 35) step();
    cont_mode = 1'b0;

    // Random traffic with valid drops, then drain
    rand_mode = 1'b1;
    repeat (1500) step();
    rand_mode = 1'b0;
    repeat (200) step();

    // Reset mid-frame after requester 1 moved the pointer to 2
    have[1] = 1'b1;
    word[1] = rnd_word();
    got = 1'b0;
    for (int t = 0; t < 100 && !got; t++) begin
      step();
      got = acc[1];
    end
    chk("reset_setup_accept", got, 1);
    repeat (10) step();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midreset_tx_start", tx_start, 0);
    chk("midreset_tx_din", tx_din, 0);
    chk("midreset_busy", busy, 0);
    chk("midreset_grant_id", grant_id, 0);
    chk("midreset_req_ready", req_ready, 0);
    sb.delete();
    nstarts = 0;
    acc = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_ptr = 0;
    m_next_ok = 0;
    for (int i = 0; i < NREQ; i++) begin
      have[i] = 1'b1;
      word[i] = rnd_word();
    end
    step();
    chk("post_reset_grant", req_ready, 4'b0001);
    repeat (200) step();

    chk("scoreboard_drained", sb.size(), 0);
    chk("dut2_start_count_ok", (n2 >= 50), 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
